// File: rtl/dsp_nco_pkg.sv
// Shared types and constants for the NCO phase front end.
// Optional dither is enabled by defining DSP_NCO_DITHER_EN.
package dsp_nco_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } nco_state_e;

  localparam int unsigned DEF_PHASE_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH  = 10;

  // Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 in right-shift form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Dither width stays strictly below the address LSB weight
  function automatic int unsigned dither_bits(int unsigned pw, int unsigned aw);
    int unsigned room;
    room = pw - aw - 1;
    return (room < 16) ? room : 16;
  endfunction

endpackage

// File: rtl/dsp_nco_lfsr.sv
// 16-bit Galois LFSR used as the phase dither source.
// Only instantiated when DSP_NCO_DITHER_EN is defined.
module dsp_nco_lfsr
  import dsp_nco_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: shift right, fold taps in when the output bit is set
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  // LFSR register, reloaded with the seed on reset
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/dsp_nco_phase_gen.sv
// NCO phase accumulator: FCW integration, phase offset, truncated ROM
// address, immediate or wrap-aligned FCW updates, synchronous clear.
// Define DSP_NCO_DITHER_EN to add LFSR dither below the address LSB.
module dsp_nco_phase_gen
  import dsp_nco_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync_clr,
  input  logic [PHASE_WIDTH-1:0] fcw_data,
  input  logic                   fcw_mode,
  input  logic                   fcw_valid,
  output logic                   fcw_ready,
  input  logic [PHASE_WIDTH-1:0] poff,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   addr_valid,
  output logic                   wrap
);

  nco_state_e             state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] fcw_act_q, fcw_act_d;
  logic [PHASE_WIDTH-1:0] fcw_pend_q, fcw_pend_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   addr_valid_q, addr_valid_d;
  logic                   wrap_q, wrap_d;

  logic [PHASE_WIDTH:0]   acc_sum;
  logic [PHASE_WIDTH-1:0] phase_sum;
  logic [PHASE_WIDTH-1:0] dither_ext;

`ifdef DSP_NCO_DITHER_EN
  localparam int unsigned DITHER_W    = dither_bits(PHASE_WIDTH, ADDR_WIDTH);
  localparam logic [15:0] DITHER_MASK = 16'hFFFF >> (16 - DITHER_W);

  logic [15:0] lfsr_state;

  dsp_nco_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  assign dither_ext = PHASE_WIDTH'(lfsr_state & DITHER_MASK);
`else
  assign dither_ext = '0;
`endif

  assign fcw_ready = (state_q == IDLE);

  // Next-state: FCW handshake, deferred release, accumulator and outputs
  always_comb begin
    acc_sum   = {1'b0, acc_q} + {1'b0, fcw_act_q};
    phase_sum = acc_q + poff + dither_ext;

    state_d      = state_q;
    acc_d        = acc_q;
    fcw_act_d    = fcw_act_q;
    fcw_pend_d   = fcw_pend_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    wrap_d       = 1'b0;

    // Transfer is only possible in IDLE, so it never collides with a release
    if (fcw_valid && (state_q == IDLE)) begin
      if (!fcw_mode) begin
        fcw_act_d = fcw_data;
      end else begin
        fcw_pend_d = fcw_data;
        state_d    = PENDING;
      end
    end

    if ((state_q == PENDING) && (sync_clr || (en && acc_sum[PHASE_WIDTH]))) begin
      fcw_act_d = fcw_pend_q;
      state_d   = IDLE;
    end

    if (sync_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d        = acc_sum[PHASE_WIDTH-1:0];
      wrap_d       = acc_sum[PHASE_WIDTH];
      addr_d       = ADDR_WIDTH'(phase_sum >> (PHASE_WIDTH - ADDR_WIDTH));
      addr_valid_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      fcw_act_q    <= '0;
      fcw_pend_q   <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fcw_act_q    <= fcw_act_d;
      fcw_pend_q   <= fcw_pend_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_dsp_nco_phase_gen.sv
// Directed self-checking bench for dsp_nco_phase_gen (PHASE_WIDTH=32,
// ADDR_WIDTH=10). The dither scenario runs only with DSP_NCO_DITHER_EN.
module tb_dsp_nco_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync_clr;
  logic [31:0] fcw_data;
  logic        fcw_mode;
  logic        fcw_valid;
  logic        fcw_ready;
  logic [31:0] poff;
  logic [9:0]  addr;
  logic        addr_valid;
  logic        wrap;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dsp_nco_phase_gen #(
    .PHASE_WIDTH (32),
    .ADDR_WIDTH  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync_clr   (sync_clr),
    .fcw_data   (fcw_data),
    .fcw_mode   (fcw_mode),
    .fcw_valid  (fcw_valid),
    .fcw_ready  (fcw_ready),
    .poff       (poff),
    .addr       (addr),
    .addr_valid (addr_valid),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect one issued sample with the given address and wrap flag
  task automatic expect_sample(input string tag, input int unsigned a, input logic w);
    tick();
    check_eq({tag, ".addr"}, 32'(addr), 32'(a));
    check_eq({tag, ".valid"}, 32'(addr_valid), 32'd1);
    check_eq({tag, ".wrap"}, 32'(wrap), 32'(w));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync_clr = 1'b0;
    fcw_data = '0; fcw_mode = 1'b0; fcw_valid = 1'b0; poff = '0;
    tick(); tick();

    // Reset state
    check_eq("rst.addr",  32'(addr), 32'd0);
    check_eq("rst.valid", 32'(addr_valid), 32'd0);
    check_eq("rst.wrap",  32'(wrap), 32'd0);
    check_eq("rst.ready", 32'(fcw_ready), 32'd1);

    // Immediate FCW load of a quarter turn
    rst = 1'b0;
    fcw_valid = 1'b1; fcw_mode = 1'b0; fcw_data = 32'h4000_0000;
    tick();
    check_eq("imm.valid_idle", 32'(addr_valid), 32'd0);
    fcw_valid = 1'b0; en = 1'b1;
    for (int k = 0; k < 8; k++)
      expect_sample("seq", (k % 4) * 256, (k % 4) == 3);

    // Half-turn phase offset; wrap still tracks the accumulator
    poff = 32'h8000_0000;
    for (int k = 0; k < 4; k++)
      expect_sample("poff", ((k + 2) % 4) * 256, k == 3);
    poff = '0;

    // Deferred FCW offered at acc=0x40000000, released on the wrap edge
    expect_sample("def.pre", 0, 1'b0);
    check_eq("def.ready_before", 32'(fcw_ready), 32'd1);
    fcw_valid = 1'b1; fcw_mode = 1'b1; fcw_data = 32'h2000_0000;
    expect_sample("def.load", 256, 1'b0);
    fcw_valid = 1'b0;
    check_eq("def.ready_pend0", 32'(fcw_ready), 32'd0);
    expect_sample("def.hold", 512, 1'b0);
    check_eq("def.ready_pend1", 32'(fcw_ready), 32'd0);
    expect_sample("def.wrap", 768, 1'b1);
    check_eq("def.ready_after", 32'(fcw_ready), 32'd1);
    for (int k = 0; k < 4; k++)
      expect_sample("def.new", k * 128, 1'b0);

    // sync_clr while PENDING: clears acc and applies the pending FCW
    fcw_valid = 1'b1; fcw_mode = 1'b1; fcw_data = 32'h4000_0000;
    expect_sample("clr.load", 512, 1'b0);
    fcw_valid = 1'b0;
    check_eq("clr.ready_pend", 32'(fcw_ready), 32'd0);
    sync_clr = 1'b1;
    tick();
    check_eq("clr.valid", 32'(addr_valid), 32'd0);
    check_eq("clr.wrap",  32'(wrap), 32'd0);
    check_eq("clr.ready", 32'(fcw_ready), 32'd1);
    sync_clr = 1'b0;
    for (int k = 0; k < 4; k++)
      expect_sample("clr.seq", k * 256, k == 3);

    // en low for three cycles: address holds, no valid, no wrap
    expect_sample("gap.a", 0, 1'b0);
    expect_sample("gap.b", 256, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("gap.addr",  32'(addr), 32'd256);
      check_eq("gap.valid", 32'(addr_valid), 32'd0);
      check_eq("gap.wrap",  32'(wrap), 32'd0);
    end
    en = 1'b1;
    expect_sample("gap.resume0", 512, 1'b0);
    expect_sample("gap.resume1", 768, 1'b1);

    // Deferred transfer on the wrap edge itself is not released by it
    expect_sample("same.a", 0, 1'b0);
    expect_sample("same.b", 256, 1'b0);
    expect_sample("same.c", 512, 1'b0);
    fcw_valid = 1'b1; fcw_mode = 1'b1; fcw_data = 32'h1000_0000;
    expect_sample("same.wrap", 768, 1'b1);
    fcw_valid = 1'b0;
    check_eq("same.ready", 32'(fcw_ready), 32'd0);
    expect_sample("same.old_fcw", 0, 1'b0);
    check_eq("same.still_pend", 32'(fcw_ready), 32'd0);

    // Reset while PENDING discards the pending FCW
    rst = 1'b1;
    tick();
    check_eq("rstp.ready", 32'(fcw_ready), 32'd1);
    check_eq("rstp.addr",  32'(addr), 32'd0);
    check_eq("rstp.valid", 32'(addr_valid), 32'd0);
    rst = 1'b0;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    expect_sample("rstp.fcw0_a", 0, 1'b0);
    expect_sample("rstp.fcw0_b", 0, 1'b0);

`ifdef DSP_NCO_DITHER_EN
    // FCW=0, poff=0: dither alone must never move the address
    begin
      int unsigned nonzero;
      nonzero = 0;
      for (int k = 0; k < 1000; k++) begin
        tick();
        if (addr != '0) nonzero++;
      end
      check_eq("dith.nonzero_count", 32'(nonzero), 32'd0);
    end
`endif

    en = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
